// File: rtl/obc_dft_pkg.sv
// Shared types and constants for the OBC/DA DFT bit-serial controller.
package obc_dft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_PTS    = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ROM_W  = 32;
    localparam int DEF_ACC_W  = 48;
    localparam int EXT_W      = 64;

    // Replicates bit (width-1) of value into every higher bit; callers cast the result down.
    function automatic logic [EXT_W-1:0] sign_ext(input logic [EXT_W-1:0] value, input int width);
        sign_ext = value;
        for (int i = 0; i < EXT_W; i++) begin
            if (i >= width) sign_ext[i] = value[width-1];
        end
    endfunction

endpackage

// File: rtl/obc_dft_bitserial_ctrl_plane_mux.sv
// Combinational bit-plane selector: gathers bit `plane` of each of the 16 samples.
module obc_plane_mux
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [NUM_PTS*DATA_W-1:0]  samples,
    input  logic [$clog2(DATA_W)-1:0]  plane,
    output logic [NUM_PTS-1:0]         bits
);

    always_comb begin
        for (int k = 0; k < NUM_PTS; k++) begin
            bits[k] = samples[k*DATA_W + int'(plane)];
        end
    end

endmodule

// File: rtl/obc_dft_bitserial_ctrl.sv
// Bit-serial sequencer and Horner accumulator for one OBC/DA DFT bin.
// Optional macro OBC_OFFSET_EN preloads the accumulator with OFFSET.
module obc_dft_bitserial_ctrl
    import obc_dft_pkg::*;
#(
    parameter int                       DATA_W = DEF_DATA_W,
    parameter int                       ROM_W  = DEF_ROM_W,
    parameter int                       ACC_W  = DEF_ACC_W,
    parameter logic signed [ACC_W-1:0]  OFFSET = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_PTS*DATA_W-1:0]   in_samples,
    output logic [NUM_PTS-1:0]          x_plane,
    output logic                        m_out,
    input  logic [ROM_W-1:0]            rom_in,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            result
);

    localparam int P_W = $clog2(DATA_W);

`ifdef OBC_OFFSET_EN
    localparam logic [ACC_W-1:0] ACC_INIT = OFFSET;
`else
    localparam logic [ACC_W-1:0] ACC_INIT = '0;
`endif

    state_t                      state, state_nxt;
    logic [P_W-1:0]              plane;
    logic [NUM_PTS*DATA_W-1:0]   samples;
    logic [ACC_W-1:0]            acc, acc_nxt, rom_ext;
    logic [NUM_PTS*DATA_W-1:0]   mux_src;
    logic [P_W-1:0]              mux_plane;
    logic [NUM_PTS-1:0]          mux_bits;
    logic                        accept, last_plane;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (plane == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign accept     = (state == IDLE) && in_valid;
    assign last_plane = (state == RUN) && (plane == '0);
    assign rom_ext    = ACC_W'(sign_ext(EXT_W'(rom_in), ROM_W));
    assign acc_nxt    = (acc << 1) + rom_ext;

    // The first plane is taken straight from in_samples so x_plane is valid in RUN cycle 1.
    assign mux_src   = (state == IDLE) ? in_samples : samples;
    assign mux_plane = (state == IDLE) ? P_W'(DATA_W - 1) : plane - P_W'(1);

    obc_plane_mux #(.DATA_W(DATA_W)) u_plane_mux (
        .samples (mux_src),
        .plane   (mux_plane),
        .bits    (mux_bits)
    );

    // NOTE: the sample registers are ordinary flops, so they are reset along with the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            samples <= '0;
            plane   <= '0;
            acc     <= ACC_INIT;
            result  <= '0;
            x_plane <= '0;
            m_out   <= 1'b0;
        end else if (accept) begin
            samples <= in_samples;
            plane   <= P_W'(DATA_W - 1);
            acc     <= ACC_INIT;
            x_plane <= mux_bits;
            m_out   <= 1'b1;
        end else if (state == RUN) begin
            acc     <= acc_nxt;
            plane   <= last_plane ? '0 : plane - P_W'(1);
            x_plane <= last_plane ? '0 : mux_bits;
            m_out   <= 1'b0;
            if (last_plane) result <= acc_nxt;
        end
    end

endmodule

// File: doc/obc_dft_bitserial_ctrl.md
Name: obc_dft_bitserial_ctrl

Overview:
- Bit-serial sequencer for one OBC/DA DFT output bin.
- Accepts a frame of 16 real samples and presents them to the imag/real OBC ROM-accumulator stage one bit-plane per cycle, MSB plane first.
- Drives the sign-select line `m` high only on the MSB plane.
- Accumulates the combinational ROM stage output with shift-and-add (Horner form) and hands the finished bin value downstream over a valid/ready handshake.

Parameters:
- DATA_W, 16: sample width; equals the number of bit-planes and RUN cycles.
- ROM_W, 32: width of the ROM-stage result (`rom_in`), two's complement.
- ACC_W, 48: accumulator/result width; must be ≥ ROM_W+DATA_W.
- OFFSET, 0: signed ACC_W-bit accumulator preload; used only with OBC_OFFSET_EN.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: frame available.
- in_ready, output, 1: controller can accept a frame.
- in_samples, input, 16*DATA_W: sample k occupies bits [k*DATA_W +: DATA_W].
- x_plane, output, 16: bit p of samples 0..15; bit k drives ROM input x0k.
- m_out, output, 1: ROM sign-select; 1 on the MSB plane only.
- rom_in, input, ROM_W: combinational ROM-stage result for the current x_plane/m_out.
- busy, output, 1: high in RUN.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- result, output, ACC_W: signed bin value.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, x_plane=0, m_out=0, result=0, plane counter=0, sample registers=0, accumulator=0 (OFFSET with the macro).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_samples, set the plane counter to DATA_W-1, clear the accumulator, go to RUN.
- RUN:
  - Lasts exactly DATA_W cycles; in_ready=0, busy=1.
  - x_plane and m_out are registered outputs, valid throughout each RUN cycle: x_plane[k] = sample k bit p, m_out = (p==DATA_W-1).
  - At each RUN clock edge: acc <= (acc<<1) + sign_ext(rom_in), modulo 2^ACC_W.
  - Then p decrements.
  - After the p=0 edge, go to DONE with result <= acc.
- DONE:
  - out_valid=1; result holds stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE (in_ready=1 next cycle).
  - No new frame is accepted in DONE.
- Latency: frame accepted at edge T; RUN cycles T+1..T+DATA_W; out_valid asserts in cycle T+DATA_W+1.
- Minimum frame period: DATA_W+2 cycles.
- Arithmetic:
  - rom_in is sign-extended to ACC_W.
  - Negation of the MSB plane is done by the ROM stage via m_out, not by the controller.
  - The accumulator never saturates.
- x_plane and m_out return to 0 outside RUN.
- in_samples is ignored outside the IDLE accept cycle.
- rst in any state, including mid-RUN or while out_valid with out_ready=0, aborts the frame and restores reset values in the next cycle; the partial result is discarded.
- in_valid held high through DONE is not accepted until IDLE.

Optional Feature:
- Macro: OBC_OFFSET_EN.
- Defined: the accumulator is preloaded with OFFSET at frame accept and at reset. The OBC constant term (-½·ΣA scaled) is then folded in by the controller, so result = OFFSET·2^DATA_W + Σ planes (the preload is shifted DATA_W times).
- Undefined: preload is 0, the OFFSET parameter is unused, and the constant is the ROM/downstream responsibility.

Decomposition:
- Shared package obc_dft_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - NUM_PTS=16;
  - default DATA_W/ROM_W/ACC_W constants;
  - a sign-extension function.
- One natural sub-module, obc_plane_mux: combinational selection of bit p from the 16 latched samples into a 16-bit plane.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Bench ROM model for the first three scenarios: rom_in = m_out ? -x_plane[0] : x_plane[0], so result equals signed sample 0.
- Sample0=16'hFFFF, others 0 → result=-1; out_valid exactly 17 cycles after accept; m_out high only in RUN cycle 1.
- Sample0=16'h7FFF → result=32767; sample0=16'h8000 → result=-32768.
- Hold out_ready=0 for 5 cycles in DONE → result stable, out_valid stays 1, in_ready stays 0 despite in_valid=1; release → IDLE and next frame accepted one cycle later.
- Assert rst in RUN cycle 7 → next cycle IDLE, out_valid=0, x_plane=0; a following frame with sample0=16'h0005 → result=5.
- Full ROM model (sum of ±x_plane[k]·k) on a random 16-sample frame → result matches the golden bit-serial sum; with OBC_OFFSET_EN and OFFSET=3, result increases by 3·2^16.
